reg_file_mp: RTL
================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter XLEN, default 32, data width per register.
REQ-002 Parameter NREGS, default 32, register count (power of 2, >=2); ABITS = log2(NREGS).
REQ-003 Parameter NREAD, default 2, read port count (>=1).
REQ-004 Parameter NWRITE, default 2, write port count (>=1).
REQ-005 Parameter BYPASS, default 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only.
REQ-006 i_clk  in  1  single clock; all state changes on rising edge.
REQ-007 i_rstN  in  1  asynchronous, active-low reset.
REQ-008 i_regWrite  in  NWRITE  per-port write enable.
REQ-009 i_writeRegSelect  in  NWRITE*ABITS  per-port write address; port k at bits [k*ABITS +: ABITS].
REQ-010 i_dataIn  in  NWRITE*XLEN  per-port write data, packed the same way.
REQ-011 i_regSelect  in  NREAD*ABITS  per-port read address.
REQ-012 o_dataOut  out  NREAD*XLEN  per-port read data, combinational.
REQ-013 i_reserve  in  1  mark register i_reserveSelect busy (pending writeback).
REQ-014 i_reserveSelect  in  ABITS  register to reserve.
REQ-015 o_busy  out  NREAD  per-read-port busy flag of the addressed register, combinational.
REQ-016 o_wrCollision  out  1  registered pulse: write-port address collision occurred last cycle.

Function
REQ-017 Register 0 SHALL read as 0 on every port; writes and reservations to register 0 are ignored; it is never busy.
REQ-018 On rising edge, each enabled write port k with nonzero address SHALL store its i_dataIn slice into that register.
REQ-019 If several enabled write ports target the same register in one cycle, the highest-index port SHALL win.
REQ-020 o_wrCollision SHALL be 1 for exactly the cycle after an edge where >=2 enabled ports targeted the same nonzero register, else 0.
REQ-021 BYPASS=1: a read addressing a nonzero register being written this cycle SHALL return the winning port's i_dataIn combinationally (0-cycle read-after-write).
REQ-022 BYPASS=0: reads SHALL return the stored value; new data visible the cycle after the write edge.
REQ-023 Busy bit of a register SHALL set on an edge with i_reserve=1 addressing it and clear on an edge where any enabled write port targets it.
REQ-024 Reserve and write to the same register on the same edge: busy SHALL end set (new reservation wins); data is still written.
REQ-025 o_busy SHALL reflect the stored busy bit only (no forwarding of same-cycle reserve or clear).
REQ-026 Read ports SHALL be independent; any ports may address the same register.
REQ-027 Write-port addresses and data SHALL be ignored when the matching i_regWrite bit is 0.

Reset
REQ-028 i_rstN low SHALL immediately (asynchronously) clear all registers to 0, all busy bits to 0 and o_wrCollision to 0.
REQ-029 While i_rstN is low, writes and reservations SHALL be ignored; o_dataOut reads 0 and o_busy reads 0 on all ports.
REQ-030 Reset deassertion SHALL be treated as synchronous to i_clk by the instantiator; the first edge with i_rstN high performs normal operation.
REQ-031 Reset asserted mid-cycle after a write edge SHALL discard that written data.

Verification
REQ-032 Reset, then read all registers on both ports -> all 0, o_busy=0, o_wrCollision=0.
REQ-033 Port0 writes 42 to x5, port1 writes 7 to x6, same edge; read x5/x6 -> 42/7; write 99 to x0 -> x0 reads 0.
REQ-034 Both ports write x10 (port0=100, port1=200) -> x10 reads 200, o_wrCollision=1 for one cycle then 0.
REQ-035 BYPASS=1: write 0xDEAD to x3 with read port1 on x3 -> o_dataOut port1 = 0xDEAD before the edge; BYPASS=0 -> old value until after the edge.
REQ-036 Reserve x7 -> o_busy=1 next cycle; write x7 -> busy 0 after edge; reserve+write x7 same edge -> busy stays 1, data updated; reserve x0 -> busy 0.
REQ-037 Write 55 to x9, assert i_rstN low between edges -> x9 reads 0 immediately, busy bits cleared, no write accepted until release.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-ported register file with x0 hardwired to zero, highest-port-wins writes,
// optional same-cycle write forwarding, per-register busy (scoreboard) bits and a collision flag.
module rf_rd_port #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int ABITS = 5
) (
  input  logic [NREGS-1:0][XLEN-1:0] view,
  input  logic [NREGS-1:0]           busy_q,
  input  logic [ABITS-1:0]           sel,
  output logic [XLEN-1:0]            data,
  output logic                       busy
);
  assign data = view[sel];
  assign busy = busy_q[sel];
endmodule

module reg_file_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  parameter int BYPASS = 1,
  localparam int ABITS = $clog2(NREGS)
) (
  input  logic                    i_clk,
  input  logic                    i_rstN,
  input  logic [NWRITE-1:0]       i_regWrite,
  input  logic [NWRITE*ABITS-1:0] i_writeRegSelect,
  input  logic [NWRITE*XLEN-1:0]  i_dataIn,
  input  logic [NREAD*ABITS-1:0]  i_regSelect,
  output logic [NREAD*XLEN-1:0]   o_dataOut,
  input  logic                    i_reserve,
  input  logic [ABITS-1:0]        i_reserveSelect,
  output logic [NREAD-1:0]        o_busy,
  output logic                    o_wrCollision
);
  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           busy_q;
  logic [NREGS-1:0][XLEN-1:0] wr_val;
  logic [NREGS-1:0]           wr_hit;
  logic [NREGS-1:0][XLEN-1:0] view;
  logic                       coll;
  logic [ABITS-1:0]           waddr;

  // Ascending port scan so the highest enabled port overrides; a second hit on
  // an already-claimed register is a collision. x0 is never claimed.
  always_comb begin
    wr_hit = '0;
    wr_val = '0;
    coll   = 1'b0;
    waddr  = '0;
    for (int k = 0; k < NWRITE; k++) begin
      waddr = i_writeRegSelect[k*ABITS +: ABITS];
      if (i_regWrite[k] && waddr != '0) begin
        if (wr_hit[waddr]) coll = 1'b1;
        wr_hit[waddr] = 1'b1;
        wr_val[waddr] = i_dataIn[k*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      regs          <= '0;
      busy_q        <= '0;
      o_wrCollision <= 1'b0;
    end else begin
      o_wrCollision <= coll;
      for (int r = 1; r < NREGS; r++) begin
        if (wr_hit[r]) regs[r] <= wr_val[r];
        // a new reservation outranks the writeback clearing the old one
        if (i_reserve && i_reserveSelect == ABITS'(r)) busy_q[r] <= 1'b1;
        else if (wr_hit[r])                           busy_q[r] <= 1'b0;
      end
    end
  end

  // Forwarding is suppressed during reset so reads stay at zero.
  always_comb begin
    for (int r = 0; r < NREGS; r++)
      view[r] = (BYPASS != 0 && i_rstN && wr_hit[r]) ? wr_val[r] : regs[r];
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    rf_rd_port #(.XLEN(XLEN), .NREGS(NREGS), .ABITS(ABITS)) u_rd (
      .view   (view),
      .busy_q (busy_q),
      .sel    (i_regSelect[p*ABITS +: ABITS]),
      .data   (o_dataOut[p*XLEN +: XLEN]),
      .busy   (o_busy[p])
    );
  end
endmodule
